// File: rtl/writeback_pkg.sv
// Shared types for the writeback merge path: result payload, source tag and default FIFO depth.
package writeback_pkg;

    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] result;
        logic [4:0]  writereg;
    } writeback_data_t;

    typedef enum logic {WB_SRC_ALU, WB_SRC_MEM} wb_src_e;

endpackage

// File: rtl/writeback_fifo.sv
// Small per-source result FIFO with push/pop/flush; head is the oldest entry, valid when count != 0.
module writeback_fifo
    import writeback_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  writeback_data_t   push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [PTR_W:0]    count,
    output writeback_data_t   head
);

    writeback_data_t r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Storage carries no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and memory results into one registered writeback stream (memory priority, ALU starvation guard).
// Optional performance counters are built when WB_PERF_CNT_EN is defined.
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            alu_valid,
    input  writeback_data_t alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  writeback_data_t mem_data,
    output logic            mem_ready,
    input  logic            flush,
    output logic            wb_valid,
    output writeback_data_t wb_data,
    output wb_src_e         wb_src
`ifdef WB_PERF_CNT_EN
    ,
    output logic [63:0]     perf_commits,
    output logic [63:0]     perf_alu_starved
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

    logic [CNT_W-1:0] w_alu_count;
    logic [CNT_W-1:0] w_mem_count;
    writeback_data_t  w_alu_head;
    writeback_data_t  w_mem_head;
    logic             w_alu_has;
    logic             w_mem_has;
    logic             w_alu_win;
    logic             w_mem_win;
    logic             w_alu_push;
    logic             w_mem_push;
    logic             w_alu_pop;
    logic             w_mem_pop;

    logic [3:0]       r_starve_cnt;
    logic             r_wb_valid;
    writeback_data_t  r_wb_data;
    wb_src_e          r_wb_src;

    // Ready comes from registered counts only, so there is no valid->ready path.
    assign alu_ready  = (w_alu_count < FULL_CNT);
    assign mem_ready  = (w_mem_count < FULL_CNT);
    assign w_alu_push = alu_valid && alu_ready && !flush;
    assign w_mem_push = mem_valid && mem_ready && !flush;

    assign w_alu_has = (w_alu_count != '0);
    assign w_mem_has = (w_mem_count != '0);
    assign w_alu_win = w_alu_has && (!w_mem_has || (r_starve_cnt == STARVE_MAX));
    assign w_mem_win = w_mem_has && !w_alu_win;
    assign w_alu_pop = w_alu_win && !flush;
    assign w_mem_pop = w_mem_win && !flush;

    writeback_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_alu_push),
        .push_data (alu_data),
        .pop       (w_alu_pop),
        .flush     (flush),
        .count     (w_alu_count),
        .head      (w_alu_head)
    );

    writeback_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_mem_push),
        .push_data (mem_data),
        .pop       (w_mem_pop),
        .flush     (flush),
        .count     (w_mem_count),
        .head      (w_mem_head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_src     <= WB_SRC_ALU;
            r_starve_cnt <= '0;
        end else if (flush) begin
            r_wb_valid   <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_wb_valid <= w_alu_win || w_mem_win;
            if (w_alu_win) begin
                r_wb_data <= w_alu_head;
                r_wb_src  <= WB_SRC_ALU;
            end else if (w_mem_win) begin
                r_wb_data <= w_mem_head;
                r_wb_src  <= WB_SRC_MEM;
            end
            // Counts consecutive losses of a waiting ALU head; saturation is moot since the ALU then wins.
            if (!w_alu_has || w_alu_win) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_data  = r_wb_data;
    assign wb_src   = r_wb_src;

`ifdef WB_PERF_CNT_EN
    logic [63:0] r_perf_commits;
    logic [63:0] r_perf_alu_starved;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_commits     <= '0;
            r_perf_alu_starved <= '0;
        end else if (!flush) begin
            if (w_alu_win || w_mem_win) begin
                r_perf_commits <= r_perf_commits + 64'd1;
            end
            if (w_alu_has && w_mem_win) begin
                r_perf_alu_starved <= r_perf_alu_starved + 64'd1;
            end
        end
    end

    assign perf_commits     = r_perf_commits;
    assign perf_alu_starved = r_perf_alu_starved;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter against a queue-based reference model; checks perf counters when WB_PERF_CNT_EN is defined.
module tb_writeback_arbiter;
    import writeback_pkg::*;

    localparam int D = 2;
    localparam int L = 4;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            alu_valid = 1'b0;
    writeback_data_t alu_data = '0;
    logic            alu_ready;
    logic            mem_valid = 1'b0;
    writeback_data_t mem_data = '0;
    logic            mem_ready;
    logic            flush = 1'b0;
    logic            wb_valid;
    writeback_data_t wb_data;
    wb_src_e         wb_src;
`ifdef WB_PERF_CNT_EN
    logic [63:0]     perf_commits;
    logic [63:0]     perf_alu_starved;
`endif

    writeback_arbiter #(.FIFO_DEPTH(D), .STARVE_LIMIT(L)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .alu_valid (alu_valid),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_src    (wb_src)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_commits     (perf_commits),
        .perf_alu_starved (perf_alu_starved)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    writeback_data_t aq[$];
    writeback_data_t mq[$];
    int              m_starve;
    logic            m_valid;
    writeback_data_t m_data;
    wb_src_e         m_src;
    logic [63:0]     m_commits;
    logic [63:0]     m_starved;
    logic            a_acc;
    logic            m_acc;

    function automatic writeback_data_t rnd_data();
        writeback_data_t r;
        r.instr    = $urandom;
        r.result   = {$urandom, $urandom};
        r.writereg = 5'($urandom_range(0, 31));
        return r;
    endfunction

    task automatic model_reset();
        aq.delete();
        mq.delete();
        m_starve  = 0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_src     = WB_SRC_ALU;
        m_commits = '0;
        m_starved = '0;
    endtask

    task automatic do_reset();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        flush     = 1'b0;
        resetn    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Drives one clock of stimulus and advances the model by that edge; returns #1 after the edge.
    task automatic cycle(input logic av, input writeback_data_t ad,
                         input logic mv, input writeback_data_t md, input logic fl);
        logic ahas;
        logic mhas;
        @(negedge clk);
        alu_valid = av;
        alu_data  = ad;
        mem_valid = mv;
        mem_data  = md;
        flush     = fl;
        a_acc = av && (aq.size() < D) && !fl;
        m_acc = mv && (mq.size() < D) && !fl;
        if (fl) begin
            aq.delete();
            mq.delete();
            m_starve = 0;
            m_valid  = 1'b0;
        end else begin
            ahas = (aq.size() > 0);
            mhas = (mq.size() > 0);
            m_valid = ahas || mhas;
            if (ahas && (!mhas || m_starve == L)) begin
                m_data   = aq.pop_front();
                m_src    = WB_SRC_ALU;
                m_starve = 0;
            end else if (mhas) begin
                m_data = mq.pop_front();
                m_src  = WB_SRC_MEM;
                if (ahas) begin
                    m_starved = m_starved + 64'd1;
                    m_starve  = (m_starve + 1 > L) ? L : m_starve + 1;
                end else begin
                    m_starve = 0;
                end
            end
            if (m_valid) m_commits = m_commits + 64'd1;
            if (a_acc) aq.push_back(ad);
            if (m_acc) mq.push_back(md);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++;
        if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b expected 0", wb_valid);
        else n_pass++;
        n_total++;
        if (wb_data !== '0) $display("FAIL reset_wb_data: got %h expected 0", wb_data);
        else n_pass++;
        n_total++;
        if (wb_src !== WB_SRC_ALU) $display("FAIL reset_wb_src: got %0d expected %0d", wb_src, WB_SRC_ALU);
        else n_pass++;
        n_total++;
        if ({alu_ready, mem_ready} !== 2'b11) $display("FAIL reset_ready: got %b expected 11", {alu_ready, mem_ready});
        else n_pass++;
`ifdef WB_PERF_CNT_EN
        n_total++;
        if (perf_commits !== 64'd0 || perf_alu_starved !== 64'd0)
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_commits, perf_alu_starved);
        else n_pass++;
`endif
    endtask

    task automatic test_single_alu();
        writeback_data_t a;
        a = rnd_data();
        a.result = 64'h1234;
        cycle(1'b1, a, 1'b0, '0, 1'b0);
        n_total++;
        if (wb_valid !== 1'b0) $display("FAIL single_after_e0: got valid %b expected 0", wb_valid);
        else n_pass++;
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        n_total++;
        if (wb_valid !== 1'b1 || wb_src !== WB_SRC_ALU || wb_data.result !== 64'h1234)
            $display("FAIL single_commit: got v=%b src=%0d res=%h expected v=1 src=0 res=1234", wb_valid, wb_src, wb_data.result);
        else n_pass++;
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        n_total++;
        if (wb_valid !== 1'b0) $display("FAIL single_idle_after: got valid %b expected 0", wb_valid);
        else n_pass++;
    endtask

    task automatic test_contention();
        writeback_data_t a;
        writeback_data_t m;
        a = rnd_data();
        m = rnd_data();
        cycle(1'b1, a, 1'b1, m, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        n_total++;
        if (wb_valid !== 1'b1 || wb_src !== WB_SRC_MEM || wb_data !== m)
            $display("FAIL contention_mem_first: got v=%b src=%0d data=%h expected v=1 src=1 data=%h", wb_valid, wb_src, wb_data, m);
        else n_pass++;
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        n_total++;
        if (wb_valid !== 1'b1 || wb_src !== WB_SRC_ALU || wb_data !== a)
            $display("FAIL contention_alu_next: got v=%b src=%0d data=%h expected v=1 src=0 data=%h", wb_valid, wb_src, wb_data, a);
        else n_pass++;
    endtask

    task automatic test_starvation();
        writeback_data_t a;
        do_reset();
        a = rnd_data();
        cycle(1'b1, a, 1'b1, rnd_data(), 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0, '0, 1'b1, rnd_data(), 1'b0);
            n_total++;
            if (k < 5) begin
                if (wb_valid !== 1'b1 || wb_src !== WB_SRC_MEM)
                    $display("FAIL starve_mem_cycle%0d: got v=%b src=%0d expected v=1 src=1", k, wb_valid, wb_src);
                else n_pass++;
            end else begin
                if (wb_valid !== 1'b1 || wb_src !== WB_SRC_ALU || wb_data !== a)
                    $display("FAIL starve_alu_forced: got v=%b src=%0d data=%h expected v=1 src=0 data=%h", wb_valid, wb_src, wb_data, a);
                else n_pass++;
            end
        end
`ifdef WB_PERF_CNT_EN
        n_total++;
        if (perf_alu_starved !== 64'd4) $display("FAIL starve_perf: got %0d expected 4", perf_alu_starved);
        else n_pass++;
`endif
        repeat (2) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_full_fifo();
        writeback_data_t items [3];
        int idx = 0;
        int k = 0;
        int saw_not_ready = 0;
        for (int i = 0; i < 3; i++) items[i] = rnd_data();
        for (int c = 0; c < 40 && k < 3; c++) begin
            cycle(idx < 3, items[idx < 3 ? idx : 2], 1'b1, rnd_data(), 1'b0);
            if (a_acc) idx++;
            n_total++;
            if (alu_ready !== (aq.size() < D)) $display("FAIL full_alu_ready: got %b expected %b", alu_ready, aq.size() < D);
            else n_pass++;
            if (alu_ready === 1'b0) saw_not_ready++;
            n_total++;
            if (wb_valid !== m_valid || wb_data !== m_data)
                $display("FAIL full_stream: got v=%b data=%h expected v=%b data=%h", wb_valid, wb_data, m_valid, m_data);
            else n_pass++;
            if (wb_valid === 1'b1 && wb_src === WB_SRC_ALU) begin
                n_total++;
                if (wb_data !== items[k]) $display("FAIL full_order%0d: got %h expected %h", k, wb_data, items[k]);
                else n_pass++;
                k++;
            end
        end
        n_total++;
        if (k != 3 || saw_not_ready == 0)
            $display("FAIL full_complete: got commits=%0d not_ready_cycles=%0d expected 3 and >0", k, saw_not_ready);
        else n_pass++;
        repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_flush();
        writeback_data_t stale;
        cycle(1'b1, rnd_data(), 1'b1, rnd_data(), 1'b0);
        cycle(1'b1, rnd_data(), 1'b1, rnd_data(), 1'b0);
        stale = m_data;
        cycle(1'b1, rnd_data(), 1'b1, rnd_data(), 1'b1);
        n_total++;
        if (wb_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", wb_valid);
        else n_pass++;
        n_total++;
        if ({alu_ready, mem_ready} !== 2'b11) $display("FAIL flush_ready: got %b expected 11", {alu_ready, mem_ready});
        else n_pass++;
        n_total++;
        if (wb_data !== stale) $display("FAIL flush_stale_data: got %h expected %h", wb_data, stale);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b0);
            n_total++;
            if (wb_valid !== 1'b0) $display("FAIL flush_leak%0d: got valid %b expected 0", c, wb_valid);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 9) < 6, rnd_data(), $urandom_range(0, 9) < 6, rnd_data(),
                  $urandom_range(0, 19) == 0);
            n_total++;
            if (wb_valid !== m_valid || wb_data !== m_data || (m_valid && wb_src !== m_src))
                $display("FAIL random_wb c=%0d: got v=%b src=%0d data=%h expected v=%b src=%0d data=%h",
                         c, wb_valid, wb_src, wb_data, m_valid, m_src, m_data);
            else n_pass++;
            n_total++;
            if ({alu_ready, mem_ready} !== {aq.size() < D, mq.size() < D})
                $display("FAIL random_ready c=%0d: got %b%b expected %b%b", c, alu_ready, mem_ready, aq.size() < D, mq.size() < D);
            else n_pass++;
`ifdef WB_PERF_CNT_EN
            n_total++;
            if (perf_commits !== m_commits || perf_alu_starved !== m_starved)
                $display("FAIL random_perf c=%0d: got %0d/%0d expected %0d/%0d", c, perf_commits, perf_alu_starved, m_commits, m_starved);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) cycle(1'b1, rnd_data(), 1'b1, rnd_data(), 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        n_total++;
        if (wb_valid !== 1'b0 || wb_data !== '0 || wb_src !== WB_SRC_ALU)
            $display("FAIL async_reset_outputs: got v=%b src=%0d data=%h expected v=0 src=0 data=0", wb_valid, wb_src, wb_data);
        else n_pass++;
        n_total++;
        if ({alu_ready, mem_ready} !== 2'b11) $display("FAIL async_reset_ready: got %b expected 11", {alu_ready, mem_ready});
        else n_pass++;
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b0);
            n_total++;
            if (wb_valid !== 1'b0) $display("FAIL async_reset_no_commit%0d: got valid %b expected 0", c, wb_valid);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_starvation();
        test_full_fifo();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
